mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: the 8-bit CPU (port 0) and the program loader/debug port (port 1).
- Sits between both requesters and the RAM, and drives the RAM's mem_address, mem_data_in and write_ena.
- Default policy is fixed priority to the CPU, with anti-starvation promotion for the loader.
- The loader can also take exclusive ownership (lock) to download a program while the CPU is held off.

Parameters:
- MEM_ADDR_WIDTH, 8, RAM address width.
- MEM_DATA_WIDTH, 8, RAM data width.
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is promoted over the CPU (range 1..15).

Ports:
- clock  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU access request; held until cpu_gnt.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  MEM_ADDR_WIDTH  CPU address.
- cpu_wdata  input  MEM_DATA_WIDTH  CPU write data.
- cpu_gnt  output  1  access accepted this cycle.
- cpu_rvalid  output  1  read data valid pulse.
- cpu_rdata  output  MEM_DATA_WIDTH  read data.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/MEM_ADDR_WIDTH/MEM_DATA_WIDTH  loader request, same semantics as the CPU port.
- ldr_gnt, ldr_rvalid, ldr_rdata  output  1/1/MEM_DATA_WIDTH  loader response, same semantics as the CPU port.
- ldr_lock  input  1  loader requests exclusive ownership; level.
- ldr_locked  output  1  exclusive ownership granted.
- mem_data_out  input  MEM_DATA_WIDTH  RAM read data, 1 cycle after address.
- mem_data_in  output  MEM_DATA_WIDTH  RAM write data.
- mem_address  output  MEM_ADDR_WIDTH  RAM address.
- write_ena  output  1  RAM write enable.

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_n. Reset gives state=SHARED, wait_cnt=0, rd_owner=none. All outputs 0: gnt, rvalid, rdata, ldr_locked, mem_address, mem_data_in, write_ena.
- Grant is combinational in the cycle of the request. At most one gnt per cycle.
- The RAM bus is a combinational mux of the granted port's addr, wdata and we. It is driven to 0 when nothing is granted.
- write_ena = granted & we.
- Read pipeline: a granted read registers rd_owner. On the next cycle the owner's rvalid=1 and rdata=mem_data_out. The other port's rdata holds 0.
- Back-to-back grants are legal every cycle. Throughput is 1 access/cycle.
- Writes produce no rvalid.
- A requester holds addr, we and wdata stable until gnt.
- SHARED state:
  - Only one requester: that requester is granted.
  - Both requesting: CPU wins unless wait_cnt==MAX_WAIT, in which case the loader wins.
  - wait_cnt increments (saturating at MAX_WAIT) each cycle ldr_req=1 and ldr_gnt=0.
  - wait_cnt clears when ldr_gnt=1 or ldr_req=0.
- SHARED -> DRAIN when ldr_lock=1. From the cycle DRAIN is entered, cpu_gnt is forced 0.
- DRAIN state: loader requests are still granted. After one cycle (any in-flight CPU read delivers its rvalid) -> LOCKED.
- LOCKED state: ldr_locked=1, registered. Only the loader is granted. cpu_req is ignored; the CPU stalls with its request held.
- LOCKED/DRAIN -> SHARED when ldr_lock=0. ldr_locked drops in the same edge. wait_cnt clears.
- Simultaneous ldr_lock rise and a CPU request in SHARED: that cycle's CPU grant still goes ahead (the lock is seen at the edge). The transition blocks the CPU from the next cycle.
- Asynchronous reset mid-read: the pending rvalid is discarded and outputs return to their reset values immediately.
- Address arithmetic: none; addresses pass through unchanged, with no wrap handling.

Test Plan:
- Single CPU read: CPU reads addr 0x10 holding 0xA5 -> cpu_gnt same cycle, write_ena=0, mem_address=0x10; next cycle cpu_rvalid=1, cpu_rdata=0xA5, ldr_rvalid=0.
- Contention: cpu_req and ldr_req held continuously, MAX_WAIT=4 -> CPU granted 4 cycles, loader granted on the 5th; wait_cnt returns to 0 and the pattern repeats.
- Loader write: ldr write 0x3C to 0x80 with CPU idle -> ldr_gnt=1, write_ena=1, mem_address=0x80, mem_data_in=0x3C; a CPU read of 0x80 afterwards returns 0x3C.
- Lock sequence: CPU read granted the cycle ldr_lock rises -> cpu_rvalid delivered next cycle; ldr_locked=1 one cycle later; cpu_req held 10 cycles gets no gnt; ldr_lock=0 -> ldr_locked=0 and CPU granted the next cycle.
- Reset mid-read: rst_n low one cycle after a read grant -> no rvalid; all outputs 0 during reset; state SHARED after release.
- Idle bus: no requests -> mem_address=0, mem_data_in=0, write_ena=0, both gnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port program/data RAM between the 8-bit CPU (port 0) and
// the program loader / debug port (port 1).
//
// Policy
//   SHARED : the CPU has fixed priority. A loader that has been denied
//            MAX_WAIT consecutive cycles is promoted over the CPU for one grant.
//   DRAIN  : entered when ldr_lock rises. The CPU is held off and any CPU read
//            already in flight delivers its data.
//   LOCKED : the loader owns the RAM exclusively and ldr_locked is high.
//   Dropping ldr_lock in DRAIN or LOCKED returns to SHARED on the next edge.
//
// Handshake (both ports)
//   A requester raises req with we/addr/wdata and holds all of them stable
//   until gnt is seen high in the same cycle. gnt is combinational, and the
//   access is accepted in the cycle gnt is high. A granted read returns
//   rvalid=1 with rdata exactly one cycle later. Writes return nothing.
//   rdata is 0 whenever rvalid is 0.
//
// Ports
//   clock, rst_n                  clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata         CPU request
//   cpu_gnt/rvalid/rdata          CPU response
//   ldr_req/we/addr/wdata         loader request
//   ldr_gnt/rvalid/rdata          loader response
//   ldr_lock / ldr_locked         exclusive-ownership request / indication
//   mem_data_out                  RAM read data (1 cycle after address)
//   mem_address/data_in, write_ena  RAM bus, 0 when nothing is granted
//   dbg_state                     current arbiter state (0 SHARED, 1 DRAIN,
//                                 2 LOCKED)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 8,
    parameter int MAX_WAIT       = 4
) (
    input  logic                      clock,
    input  logic                      rst_n,

    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [MEM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [MEM_DATA_WIDTH-1:0] cpu_wdata,
    output logic                      cpu_gnt,
    output logic                      cpu_rvalid,
    output logic [MEM_DATA_WIDTH-1:0] cpu_rdata,

    input  logic                      ldr_req,
    input  logic                      ldr_we,
    input  logic [MEM_ADDR_WIDTH-1:0] ldr_addr,
    input  logic [MEM_DATA_WIDTH-1:0] ldr_wdata,
    output logic                      ldr_gnt,
    output logic                      ldr_rvalid,
    output logic [MEM_DATA_WIDTH-1:0] ldr_rdata,

    input  logic                      ldr_lock,
    output logic                      ldr_locked,

    input  logic [MEM_DATA_WIDTH-1:0] mem_data_out,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_in,
    output logic [MEM_ADDR_WIDTH-1:0] mem_address,
    output logic                      write_ena,

    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        SHARED = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic       rd_cpu;   // CPU read accepted last cycle
    logic       rd_ldr;   // loader read accepted last cycle

    // -------------------------------------------------------------------------
    // Grant decision. Grants are forced low while reset is asserted so that
    // every output sits at 0 during reset even if requests are still held.
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (rst_n) begin
            case (state)
                SHARED: begin
                    if (cpu_req && ldr_req) begin
                        if (wait_cnt == MAX_WAIT_C) ldr_gnt = 1'b1;
                        else                        cpu_gnt = 1'b1;
                    end else begin
                        cpu_gnt = cpu_req;
                        ldr_gnt = ldr_req;
                    end
                end
                default: ldr_gnt = ldr_req;  // DRAIN and LOCKED: CPU held off
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next state and starvation counter. The counter only advances in SHARED;
    // outside SHARED the loader is always granted, so it stays cleared and
    // returns to SHARED at 0.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wait_nxt  = 4'd0;
        case (state)
            SHARED: begin
                if (ldr_lock) state_nxt = DRAIN;
                if (ldr_req && !ldr_gnt)
                    wait_nxt = (wait_cnt == MAX_WAIT_C) ? wait_cnt : wait_cnt + 4'd1;
            end
            DRAIN:   state_nxt = ldr_lock ? LOCKED : SHARED;
            LOCKED:  if (!ldr_lock) state_nxt = SHARED;
            default: state_nxt = SHARED;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHARED;
            wait_cnt <= 4'd0;
            rd_cpu   <= 1'b0;
            rd_ldr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            rd_cpu   <= cpu_gnt & ~cpu_we;
            rd_ldr   <= ldr_gnt & ~ldr_we;
        end
    end

    // -------------------------------------------------------------------------
    // RAM bus: mux of the granted port, all zeros when idle.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        write_ena   = 1'b0;
        if (cpu_gnt) begin
            mem_address = cpu_addr;
            mem_data_in = cpu_wdata;
            write_ena   = cpu_we;
        end else if (ldr_gnt) begin
            mem_address = ldr_addr;
            mem_data_in = ldr_wdata;
            write_ena   = ldr_we;
        end
    end

    // Read returns: only the owner of last cycle's read sees data.
    assign cpu_rvalid = rd_cpu;
    assign ldr_rvalid = rd_ldr;
    assign cpu_rdata  = rd_cpu ? mem_data_out : '0;
    assign ldr_rdata  = rd_ldr ? mem_data_out : '0;

    // state is itself a flop, so this indication is registered.
    assign ldr_locked = (state == LOCKED);
    assign dbg_state  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a small behavioural RAM attached to the
// arbiter's memory bus. Inputs change 1 ns after a rising edge and outputs are
// checked at the following falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    localparam logic [1:0] ST_SHARED = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req = 1'b0, ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          ldr_gnt, ldr_rvalid;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_lock = 1'b0;
    logic          ldr_locked;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_address;
    logic          write_ena;
    logic [1:0]    dbg_state;

    mem_arbiter #(
        .MEM_ADDR_WIDTH(AW),
        .MEM_DATA_WIDTH(DW),
        .MAX_WAIT(4)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .ldr_req     (ldr_req),
        .ldr_we      (ldr_we),
        .ldr_addr    (ldr_addr),
        .ldr_wdata   (ldr_wdata),
        .ldr_gnt     (ldr_gnt),
        .ldr_rvalid  (ldr_rvalid),
        .ldr_rdata   (ldr_rdata),
        .ldr_lock    (ldr_lock),
        .ldr_locked  (ldr_locked),
        .mem_data_out(mem_data_out),
        .mem_data_in (mem_data_in),
        .mem_address (mem_address),
        .write_ena   (write_ena),
        .dbg_state   (dbg_state)
    );

    // ---------------- behavioural RAM (1-cycle read latency) ----------------
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[8'h10] = 8'hA5;
        ram[8'h02] = 8'h5A;
    end
    always @(posedge clock) begin
        if (write_ena) ram[mem_address] <= mem_data_in;
        mem_data_out <= ram[mem_address];
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point: 1 ns after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check point: next falling edge.
    task automatic settle();
        @(negedge clock);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_addr"}, 32'(mem_address), 32'h0);
        chk({tag, "_wdata"}, 32'(mem_data_in), 32'h0);
        chk({tag, "_we"}, 32'(write_ena), 32'h0);
        chk({tag, "_cgnt"}, 32'(cpu_gnt), 32'h0);
        chk({tag, "_lgnt"}, 32'(ldr_gnt), 32'h0);
    endtask

    // Watchdog: the sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [9:0] exp_lgnt;
        logic [9:0] exp_lrv;

        // ---- reset state ----
        #3;
        chk_idle_bus("rst");
        chk("rst_crv", 32'(cpu_rvalid), 32'h0);
        chk("rst_crd", 32'(cpu_rdata), 32'h0);
        chk("rst_lrv", 32'(ldr_rvalid), 32'h0);
        chk("rst_locked", 32'(ldr_locked), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_SHARED));
        tick();
        tick();
        rst_n = 1'b1;

        // ---- idle bus ----
        tick();
        settle();
        chk_idle_bus("idle");

        // ---- single CPU read of 0x10 ----
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        settle();
        chk("rd_cgnt", 32'(cpu_gnt), 32'h1);
        chk("rd_we", 32'(write_ena), 32'h0);
        chk("rd_addr", 32'(mem_address), 32'h10);
        chk("rd_lgnt", 32'(ldr_gnt), 32'h0);
        tick();
        cpu_req = 1'b0;
        settle();
        chk("rd_crv", 32'(cpu_rvalid), 32'h1);
        chk("rd_crd", 32'(cpu_rdata), 32'hA5);
        chk("rd_lrv", 32'(ldr_rvalid), 32'h0);
        chk("rd_lrd", 32'(ldr_rdata), 32'h0);
        tick();
        settle();
        chk("rd_crv_done", 32'(cpu_rvalid), 32'h0);

        // ---- loader write 0x3C to 0x80, then CPU reads it back ----
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h80; ldr_wdata = 8'h3C;
        #1;
        chk("lw_lgnt", 32'(ldr_gnt), 32'h1);
        chk("lw_we", 32'(write_ena), 32'h1);
        chk("lw_addr", 32'(mem_address), 32'h80);
        chk("lw_wdata", 32'(mem_data_in), 32'h3C);
        chk("lw_cgnt", 32'(cpu_gnt), 32'h0);
        tick();
        ldr_req = 1'b0; ldr_we = 1'b0;
        settle();
        chk("lw_lrv", 32'(ldr_rvalid), 32'h0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h80;
        settle();
        chk("rb_cgnt", 32'(cpu_gnt), 32'h1);
        tick();
        cpu_req = 1'b0;
        settle();
        chk("rb_crv", 32'(cpu_rvalid), 32'h1);
        chk("rb_crd", 32'(cpu_rdata), 32'h3C);

        // ---- contention: CPU x4, loader on the 5th, repeating ----
        exp_lgnt = 10'b10000_10000;  // bit i-1 set for cycles 5 and 10
        exp_lrv  = 10'b00001_00000;  // loader data arrives in cycle 6
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h02;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("ct_lgnt%0d", i + 1), 32'(ldr_gnt), 32'(exp_lgnt[i]));
            chk($sformatf("ct_cgnt%0d", i + 1), 32'(cpu_gnt), 32'(!exp_lgnt[i]));
            chk($sformatf("ct_lrv%0d", i + 1), 32'(ldr_rvalid), 32'(exp_lrv[i]));
            chk($sformatf("ct_lrd%0d", i + 1), 32'(ldr_rdata),
                exp_lrv[i] ? 32'h5A : 32'h0);
            if (i < 9) tick();
        end
        tick();
        cpu_req = 1'b0; ldr_req = 1'b0;
        settle();
        chk_idle_bus("ct_end");

        // ---- lock sequence ----
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        ldr_lock = 1'b1;
        settle();
        chk("lk_cgnt_edge", 32'(cpu_gnt), 32'h1);
        chk("lk_state0", 32'(dbg_state), 32'(ST_SHARED));
        chk("lk_locked0", 32'(ldr_locked), 32'h0);
        tick();
        settle();
        chk("lk_drain_crv", 32'(cpu_rvalid), 32'h1);
        chk("lk_drain_crd", 32'(cpu_rdata), 32'hA5);
        chk("lk_drain_cgnt", 32'(cpu_gnt), 32'h0);
        chk("lk_drain_locked", 32'(ldr_locked), 32'h0);
        chk("lk_state1", 32'(dbg_state), 32'(ST_DRAIN));
        tick();
        settle();
        chk("lk_locked1", 32'(ldr_locked), 32'h1);
        chk("lk_state2", 32'(dbg_state), 32'(ST_LOCKED));
        chk("lk_crv_off", 32'(cpu_rvalid), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            // loader writes while owning the RAM; CPU request stays held
            ldr_req = (i == 3); ldr_we = 1'b1; ldr_addr = 8'h20; ldr_wdata = 8'h77;
            settle();
            chk($sformatf("lk_hold_cgnt%0d", i), 32'(cpu_gnt), 32'h0);
            chk($sformatf("lk_hold_lgnt%0d", i), 32'(ldr_gnt), (i == 3) ? 32'h1 : 32'h0);
            chk($sformatf("lk_hold_locked%0d", i), 32'(ldr_locked), 32'h1);
        end
        tick();
        ldr_req = 1'b0; ldr_we = 1'b0;
        ldr_lock = 1'b0;
        settle();
        chk("ul_cgnt_same", 32'(cpu_gnt), 32'h0);
        chk("ul_locked_same", 32'(ldr_locked), 32'h1);
        tick();
        settle();
        chk("ul_locked", 32'(ldr_locked), 32'h0);
        chk("ul_cgnt", 32'(cpu_gnt), 32'h1);
        chk("ul_state", 32'(dbg_state), 32'(ST_SHARED));
        tick();
        cpu_addr = 8'h20;
        settle();
        chk("ul_crd", 32'(cpu_rdata), 32'hA5);
        chk("ul_cgnt2", 32'(cpu_gnt), 32'h1);
        tick();
        cpu_req = 1'b0;
        settle();
        chk("ul_lkwr_rd", 32'(cpu_rdata), 32'h77);

        // ---- reset in the middle of a read ----
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        settle();
        chk("rr_cgnt", 32'(cpu_gnt), 32'h1);
        tick();
        rst_n = 1'b0;  // request still held through reset
        #1;
        chk_idle_bus("rr");
        chk("rr_crv", 32'(cpu_rvalid), 32'h0);
        chk("rr_crd", 32'(cpu_rdata), 32'h0);
        chk("rr_locked", 32'(ldr_locked), 32'h0);
        cpu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("rr_post_crv", 32'(cpu_rvalid), 32'h0);
        chk("rr_post_state", 32'(dbg_state), 32'(ST_SHARED));
        chk_idle_bus("rr_post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
